time_display_driver: RTL and testbench
======================================

// Module: time_display_driver
// PURPOSE
// Consumer end of the packed 27-bit time bus produced by the 24-hour clock.
// - Periodically snapshots the bus and range-checks each field.
// - Converts the fields to BCD with a serial double-dabble FSM.
// - Drives an 8-digit multiplexed active-low 7-segment display as HH.MM.SS.mm
//   (mm = ms hundreds and tens digits).
// PARAMETERS
// REFRESH_DIV  100  kh_clk cycles between snapshot ticks (>=64)
// SCAN_DIV     1    kh_clk cycles each digit is lit before advancing (>=1)
// PORTS
// kh_clk     in   1   1 kHz system clock, all logic on posedge
// reset      in   1   asynchronous, active-high; clears all state
// disp_time  in   27  {hr[26:22], min[21:16], sec[15:10], ms[9:0]}, binary
// an         out  8   digit enables, active-low; an[7] = hour tens, an[0] = ms tens
// seg        out  7   {g,f,e,d,c,b,a}, active-low
// dp         out  1   decimal point, active-low
// busy       out  1   high while a snapshot is being converted
// time_valid out  1   last committed snapshot passed the range check
// BEHAVIOUR
// - Reset values:
//   - an=8'hFF, seg=7'h7F, dp=1, busy=0, time_valid=0.
//   - Refresh, scan and digit counters = 0; all displayed BCD digits = 0.
// - Refresh counter counts 0..REFRESH_DIV-1; tick when it equals REFRESH_DIV-1.
// - FSM IDLE->CONV->COMMIT->IDLE:
//   - IDLE: on tick, latch disp_time into snapshot, go to CONV, busy=1.
//   - CONV: 40 cycles. 4 fields in order hr,min,sec,ms; each is zero-extended
//     to 10 bits and gets 10 shift cycles (add 3 to any BCD nibble >=5, then
//     shift) into a 12-bit BCD accumulator, which is stored per field.
//   - COMMIT: 1 cycle. All 8 display digits and time_valid update together.
//     busy=0 from the next edge.
//   - Display change occurs 42 edges after the tick edge. Never partial.
// - Ticks arriving while busy are dropped; the refresh counter keeps running.
// - disp_time changes after the snapshot edge are ignored until the next tick.
// - Range check on the snapshot: hr<=23, min<=59, sec<=59, ms<=999.
//   On any violation: time_valid=0 and all 8 digits show dash (seg=7'h3F).
// - Scan:
//   - Scan counter wraps at SCAN_DIV-1; on wrap the digit index increments
//     mod 8 (7 wraps to 0).
//   - an, seg and dp are registered from the digit index:
//     an=~(8'b1<<idx), seg=decode(digit[idx]).
// - Digit mapping (index 7..0): hr tens, hr units, min tens, min units,
//   sec tens, sec units, ms hundreds, ms tens.
// - dp=0 on indices 6, 4 and 2; dp=1 otherwise.
// - Decode (active-low seg): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10,
//   blank=7F, dash=3F.
// - Reset mid-conversion aborts: FSM returns to IDLE, display digits clear to 0.
// CONFIGURATION
// HR_LEADING_BLANK_EN
// - Defined: hour-tens digit shows blank (seg=7'h7F) when its value is 0 and
//   time_valid=1.
// - Not defined: it shows "0" (seg=7'h40).
// - All other digits are unaffected in both builds.
// TESTING
// - Reset, hold disp_time=0 -> an=FF, seg=7F on the first edge.
//   Then an cycles 7F..FE; all seg=40; busy=0.
// - hr=12,min=34,sec=56,ms=789
//   -> busy high 41 cycles after tick, time_valid=1.
//   -> Digits 1,2,3,4,5,6,7,8: an=7F gives seg=79; an=FE gives seg=00.
// - min=60, others valid
//   -> after commit, time_valid=0 and every digit seg=3F, dp unchanged.
// - Change disp_time to 23:59:59.999 10 cycles into CONV
//   -> committed digits still show the prior snapshot.
//   -> Next tick shows 2,3,5,9,5,9,9,9.
// - Assert reset 20 cycles into CONV -> busy=0, digits=0, time_valid=0.
//   A fresh conversion follows after REFRESH_DIV cycles.
// - hr=5 with HR_LEADING_BLANK_EN defined -> an=7F gives seg=7F;
//   without it -> seg=40.

Source files
------------

// File: rtl/time_display_driver.sv
// time_display_driver: snapshots the packed 27-bit time bus, range-checks it,
// converts each field to BCD with a serial double-dabble engine, and scans an
// 8-digit active-low 7-segment display as HH.MM.SS.mm.
// Optional build macro: HR_LEADING_BLANK_EN (blank hour-tens digit when it is 0).
module time_display_driver #(
    parameter int unsigned REFRESH_DIV = 100,
    parameter int unsigned SCAN_DIV    = 1
) (
    input  logic        kh_clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic        time_valid
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t        state, state_nx;
    logic [RW-1:0] ref_cnt;
    logic          tick;
    logic [SW-1:0] scan_cnt;
    logic          scan_wrap;
    logic [2:0]    dig_idx;

    logic [26:0]   snap;
    logic [1:0]    field;
    logic [3:0]    bit_cnt;
    logic [11:0]   bcd_acc;
    logic [9:0]    bin_sh;
    logic [9:0]    fval;
    logic [11:0]   src_bcd;
    logic [9:0]    src_bin;
    logic [7:0]    adj_lo;
    logic [2:0]    adj_hi;
    logic [11:0]   bcd_step;
    logic [9:0]    bin_step;

    logic [7:0]    hr_bcd, min_bcd, sec_bcd, ms_bcd;
    logic [3:0]    digit [8];
    logic          dash;
    logic          range_ok;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign tick      = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

    // Free-running snapshot interval counter; keeps counting while busy.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset)     ref_cnt <= '0;
        else if (tick) ref_cnt <= '0;
        else           ref_cnt <= ref_cnt + RW'(1);
    end

    // Digit scan: dwell SCAN_DIV cycles per digit, then advance modulo 8.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // Sequencer state register; busy covers the whole CONV+COMMIT window.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
        end
    end

    // Next-state: a tick in IDLE starts a 40-cycle conversion, then one commit cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick) state_nx = CONV;
            CONV:    if (field == 2'd3 && bit_cnt == 4'd9) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Select the snapshot field being converted, zero-extended to 10 bits.
    always_comb begin
        case (field)
            2'd0:    fval = {5'd0, snap[26:22]};
            2'd1:    fval = {4'd0, snap[21:16]};
            2'd2:    fval = {4'd0, snap[15:10]};
            default: fval = snap[9:0];
        endcase
    end

    // One double-dabble step: a field's first cycle starts from a cleared
    // accumulator and the raw field value instead of the running registers.
    always_comb begin
        src_bcd = (bit_cnt == 4'd0) ? '0 : bcd_acc;
        src_bin = (bit_cnt == 4'd0) ? fval : bin_sh;
        adj_lo  = src_bcd[7:0];
        for (int unsigned n = 0; n < 2; n++) begin
            if (src_bcd[4*n +: 4] >= 4'd5) adj_lo[4*n +: 4] = src_bcd[4*n +: 4] + 4'd3;
        end
        adj_hi   = src_bcd[10:8] + ((src_bcd[11:8] >= 4'd5) ? 3'd3 : 3'd0);
        bcd_step = {adj_hi, adj_lo, src_bin[9]};
        bin_step = {src_bin[8:0], 1'b0};
    end

    // Snapshot capture and serial conversion datapath.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            snap    <= '0;
            field   <= '0;
            bit_cnt <= '0;
            bcd_acc <= '0;
            bin_sh  <= '0;
            hr_bcd  <= '0;
            min_bcd <= '0;
            sec_bcd <= '0;
            ms_bcd  <= '0;
        end else if (state == IDLE) begin
            if (tick) begin
                snap    <= disp_time;
                field   <= '0;
                bit_cnt <= '0;
            end
        end else if (state == CONV) begin
            bcd_acc <= bcd_step;
            bin_sh  <= bin_step;
            if (bit_cnt == 4'd9) begin
                bit_cnt <= '0;
                field   <= field + 2'd1;
                case (field)
                    2'd0:    hr_bcd  <= bcd_step[7:0];
                    2'd1:    min_bcd <= bcd_step[7:0];
                    2'd2:    sec_bcd <= bcd_step[7:0];
                    default: ms_bcd  <= bcd_step[11:4];
                endcase
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    assign range_ok = (snap[26:22] <= 5'd23) && (snap[21:16] <= 6'd59) &&
                      (snap[15:10] <= 6'd59) && (snap[9:0] <= 10'd999);

    // Commit all eight digits and the validity flag in a single edge.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) digit[i] <= '0;
            dash       <= 1'b0;
            time_valid <= 1'b0;
        end else if (state == COMMIT) begin
            digit[7]   <= hr_bcd[7:4];
            digit[6]   <= hr_bcd[3:0];
            digit[5]   <= min_bcd[7:4];
            digit[4]   <= min_bcd[3:0];
            digit[3]   <= sec_bcd[7:4];
            digit[2]   <= sec_bcd[3:0];
            digit[1]   <= ms_bcd[7:4];
            digit[0]   <= ms_bcd[3:0];
            dash       <= !range_ok;
            time_valid <= range_ok;
        end
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        seg_nx = seg7(digit[dig_idx]);
        if (dash) seg_nx = 7'h3F;
`ifdef HR_LEADING_BLANK_EN
        else if (dig_idx == 3'd7 && digit[7] == 4'd0 && time_valid) seg_nx = 7'h7F;
`endif
    end

    // Registered display drive: one-hot active-low anode, segments, decimal points.
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << dig_idx);
            seg <= seg_nx;
            dp  <= !(dig_idx == 3'd6 || dig_idx == 3'd4 || dig_idx == 3'd2);
        end
    end

endmodule

// File: tb/tb_time_display_driver.sv
// Testbench for time_display_driver: directed and random snapshots checked
// every cycle against an arithmetic reference model of the display.
module tb_time_display_driver;

    localparam int R     = 64;
    localparam int SD    = 2;
    localparam int NPLAN = 14;
`ifdef HR_LEADING_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic        kh_clk = 1'b0;
    logic        reset;
    logic [26:0] disp_time;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        time_valid;

    time_display_driver #(.REFRESH_DIV(R), .SCAN_DIV(SD)) dut (
        .kh_clk(kh_clk), .reset(reset), .disp_time(disp_time),
        .an(an), .seg(seg), .dp(dp), .busy(busy), .time_valid(time_valid)
    );

    always #5 kh_clk = ~kh_clk;

    int          checks = 0;
    int          failures = 0;
    int          k;
    int          conv_start;
    int          pi;
    logic [26:0] cur_in;
    logic [26:0] plan [NPLAN];
    bit          mid_en [NPLAN];
    logic [26:0] mid_val [NPLAN];
    int          sh_d [8];
    int          pend_d [8];
    bit          sh_dash, sh_valid, pend_dash, pend_valid, exp_valid;

    function automatic logic [26:0] pk(input int unsigned h, input int unsigned m,
                                       input int unsigned s, input int unsigned ms);
        return {5'(h), 6'(m), 6'(s), 10'(ms)};
    endfunction

    function automatic logic [26:0] rnd_time(input bit allow_bad);
        int unsigned h  = $urandom_range(0, 23);
        int unsigned m  = $urandom_range(0, 59);
        int unsigned s  = $urandom_range(0, 59);
        int unsigned ms = $urandom_range(0, 999);
        if (allow_bad && $urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
                0: h  = $urandom_range(24, 31);
                1: m  = $urandom_range(60, 63);
                2: s  = $urandom_range(60, 63);
                default: ms = $urandom_range(1000, 1023);
            endcase
        end
        return pk(h, m, s, ms);
    endfunction

    function automatic logic [6:0] dec(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an"},    an, 8'hFF);
        chk({tag, "_seg"},   {1'b0, seg}, 8'h7F);
        chk({tag, "_dp"},    {7'd0, dp}, 8'h01);
        chk({tag, "_busy"},  {7'd0, busy}, 8'h00);
        chk({tag, "_valid"}, {7'd0, time_valid}, 8'h00);
    endtask

    task automatic model_clear();
        k = 0;
        conv_start = 0;
        for (int i = 0; i < 8; i++) sh_d[i] = 0;
        sh_dash = 0; sh_valid = 0; exp_valid = 0;
    endtask

    task automatic run(input int n);
        int idx;
        int h, m, s, ms;
        logic [6:0] exp_seg;
        for (int i = 0; i < n; i++) begin
            @(posedge kh_clk); #1;
            k++;
            // reference model: capture on tick, valid at +41, display at +42
            if (k % R == 0) begin
                h  = int'(cur_in[26:22]);
                m  = int'(cur_in[21:16]);
                s  = int'(cur_in[15:10]);
                ms = int'(cur_in[9:0]);
                pend_valid = (h <= 23) && (m <= 59) && (s <= 59) && (ms <= 999);
                pend_dash  = !pend_valid;
                pend_d[7] = h / 10;    pend_d[6] = h % 10;
                pend_d[5] = m / 10;    pend_d[4] = m % 10;
                pend_d[3] = s / 10;    pend_d[2] = s % 10;
                pend_d[1] = ms / 100;  pend_d[0] = (ms / 10) % 10;
                conv_start = k;
            end
            if (conv_start > 0 && k == conv_start + 41) exp_valid = pend_valid;
            if (conv_start > 0 && k == conv_start + 42) begin
                sh_d = pend_d; sh_dash = pend_dash; sh_valid = pend_valid;
            end
            idx = ((k - 1) / SD) % 8;
            if (sh_dash) exp_seg = 7'h3F;
            else if (BLANK_EN && idx == 7 && sh_d[7] == 0 && sh_valid) exp_seg = 7'h7F;
            else exp_seg = dec(sh_d[idx]);

            chk("busy",  {7'd0, busy},
                {7'd0, (conv_start > 0 && k >= conv_start && k <= conv_start + 40)});
            chk("valid", {7'd0, time_valid}, {7'd0, exp_valid});
            chk("an",    an, ~(8'd1 << idx));
            chk("seg",   {1'b0, seg}, {1'b0, exp_seg});
            chk("dp",    {7'd0, dp}, {7'd0, !(idx == 6 || idx == 4 || idx == 2)});

            // stimulus for upcoming edges
            if ((k + 5) % R == 0 && pi < NPLAN) begin
                cur_in = plan[pi];
                pi++;
            end
            if (conv_start > 0 && k == conv_start + 10 && pi > 0 && mid_en[pi-1])
                cur_in = mid_val[pi-1];
            disp_time = cur_in;
        end
    endtask

    initial begin
        reset = 1'b1;
        disp_time = '0;
        cur_in = '0;
        pi = 0;
        for (int i = 0; i < NPLAN; i++) begin
            mid_en[i] = 0;
            mid_val[i] = '0;
            plan[i] = rnd_time(i >= 7);
        end
        plan[0] = '0;
        plan[1] = pk(12, 34, 56, 789);
        plan[2] = pk(12, 60, 56, 789);
        plan[3] = pk(5, 7, 8, 90);
        mid_en[3] = 1;
        mid_val[3] = pk(23, 59, 59, 999);
        plan[4] = pk(23, 59, 59, 999);
        plan[6] = pk(5, 0, 0, 0);
        plan[8] = pk(31, 63, 63, 1023);
        model_clear();

        #2;
        check_reset("init");
        repeat (3) begin
            @(posedge kh_clk); #1;
            check_reset("rst_hold");
        end
        reset = 1'b0;
        model_clear();
        run(6 * R + 20);

        // abort the conversion in flight 20 cycles in
        reset = 1'b1;
        #1;
        check_reset("rst_mid");
        repeat (2) begin
            @(posedge kh_clk); #1;
            check_reset("rst_mid_hold");
        end
        reset = 1'b0;
        model_clear();
        run(7 * R + 45);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
